// File: rtl/rca_config.sv
// Shared configuration for the RCA partial-reconfiguration scheduler: slot count, queue depth,
// bitstream id width, request record and scheduler state encoding.
package rca_config;

  localparam int unsigned NUM_RCAS              = 4;
  localparam int unsigned MAX_PR_QUEUE_REQUESTS = 8;
  localparam int unsigned BITSTREAM_ID_W        = 8;
  localparam int unsigned RCA_ID_W              = (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1;

  typedef struct packed {
    logic [RCA_ID_W-1:0]       rca_id;
    logic [BITSTREAM_ID_W-1:0] bitstream_id;
  } pr_request_t;

  typedef enum logic [1:0] {
    StIdle,
    StWaitIdle,
    StProgram
  } pr_sched_state_t;

endpackage

// File: rtl/rca_pr_queue.sv
// Circular FIFO of pending PR requests; also exposes every slot with a valid mask so the
// scheduler can look for duplicates.
module rca_pr_queue #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 10,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [Width-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       head_o,
  output logic [CntW-1:0]        count_o,
  output logic                   empty_o,
  output logic [Depth*Width-1:0] entries_o,
  output logic [Depth-1:0]       entry_valid_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: slots are only read once the pointers mark them live.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

  for (genvar i = 0; i < Depth; i++) begin : g_entry
    assign entries_o[i*Width +: Width] = mem_q[i];
    assign entry_valid_o[i] =
        ((32'(i) + 32'(Depth) - 32'(rd_ptr_q)) % 32'(Depth)) < 32'(count_q);
  end

endmodule

// File: rtl/rca_pr_scheduler.sv
// Queues PR requests and programs one RCA at a time once it drains. Define RCA_PR_DEDUP_EN to
// drop requests already queued or in progress.
module rca_pr_scheduler #(
  parameter int unsigned NUM_RCAS              = rca_config::NUM_RCAS,
  parameter int unsigned MAX_PR_QUEUE_REQUESTS = rca_config::MAX_PR_QUEUE_REQUESTS,
  parameter int unsigned BITSTREAM_ID_W        = rca_config::BITSTREAM_ID_W,
  localparam int unsigned RCA_W = (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1,
  localparam int unsigned CNT_W = $clog2(MAX_PR_QUEUE_REQUESTS + 1),
  localparam int unsigned REQ_W = RCA_W + BITSTREAM_ID_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  input  logic [RCA_W-1:0]          req_rca,
  input  logic [BITSTREAM_ID_W-1:0] req_bitstream,
  output logic                      req_ready,
  input  logic [NUM_RCAS-1:0]       rca_busy,
  output logic [NUM_RCAS-1:0]       rca_lock,
  output logic                      pr_start,
  output logic [RCA_W-1:0]          pr_rca,
  output logic [BITSTREAM_ID_W-1:0] pr_bitstream,
  input  logic                      pr_done,
  output logic [CNT_W-1:0]          queue_count
);

  rca_config::pr_sched_state_t state_q, state_d;
  logic [RCA_W-1:0]          rca_q, rca_d;
  logic [BITSTREAM_ID_W-1:0] bs_q, bs_d;
  logic                      start_q, start_d;

  logic                                   accept, push, pop, dup, q_empty;
  logic [REQ_W-1:0]                       head;
  logic [MAX_PR_QUEUE_REQUESTS*REQ_W-1:0] entries;
  logic [MAX_PR_QUEUE_REQUESTS-1:0]       entry_valid;

  assign req_ready = (queue_count != CNT_W'(MAX_PR_QUEUE_REQUESTS));
  assign accept    = req_valid && req_ready;
  assign push      = accept && !dup;
  assign pop       = (state_q == rca_config::StIdle) && !q_empty;

`ifdef RCA_PR_DEDUP_EN
  always_comb begin
    dup = (state_q != rca_config::StIdle) && (rca_q == req_rca) && (bs_q == req_bitstream);
    for (int i = 0; i < int'(MAX_PR_QUEUE_REQUESTS); i++) begin
      if (entry_valid[i] && (entries[i*REQ_W +: REQ_W] == {req_rca, req_bitstream})) dup = 1'b1;
    end
  end
`else
  logic unused_entries;
  assign unused_entries = ^{entries, entry_valid};
  assign dup            = 1'b0;
`endif

  rca_pr_queue #(
    .Depth (MAX_PR_QUEUE_REQUESTS),
    .Width (REQ_W)
  ) u_queue (
    .clk_i         (clk),
    .rst_i         (rst),
    .push_i        (push),
    .push_data_i   ({req_rca, req_bitstream}),
    .pop_i         (pop),
    .head_o        (head),
    .count_o       (queue_count),
    .empty_o       (q_empty),
    .entries_o     (entries),
    .entry_valid_o (entry_valid)
  );

  always_comb begin
    state_d = state_q;
    rca_d   = rca_q;
    bs_d    = bs_q;
    start_d = 1'b0;
    unique case (state_q)
      rca_config::StIdle: begin
        if (!q_empty) begin
          {rca_d, bs_d} = head;
          state_d       = rca_config::StWaitIdle;
        end
      end
      rca_config::StWaitIdle: begin
        if (!rca_busy[rca_q]) begin
          state_d = rca_config::StProgram;
          start_d = 1'b1;
        end
      end
      rca_config::StProgram: begin
        if (pr_done) state_d = rca_config::StIdle;
      end
      default: state_d = rca_config::StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= rca_config::StIdle;
      rca_q   <= '0;
      bs_q    <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rca_q   <= rca_d;
      bs_q    <= bs_d;
      start_q <= start_d;
    end
  end

  always_comb begin
    rca_lock = '0;
    if (state_q != rca_config::StIdle) rca_lock[rca_q] = 1'b1;
  end

  assign pr_start     = start_q;
  assign pr_rca       = rca_q;
  assign pr_bitstream = bs_q;

endmodule

// File: tb/tb_rca_pr_scheduler.sv
// Directed self-checking bench for rca_pr_scheduler; expectations follow RCA_PR_DEDUP_EN.
module tb_rca_pr_scheduler;

  logic       clk, rst;
  logic       req_valid;
  logic [1:0] req_rca;
  logic [7:0] req_bitstream;
  logic       req_ready;
  logic [3:0] rca_busy, rca_lock;
  logic       pr_start;
  logic [1:0] pr_rca;
  logic [7:0] pr_bitstream;
  logic       pr_done;
  logic [3:0] queue_count;

  int checks = 0;
  int errors = 0;

  rca_pr_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_rca       (req_rca),
    .req_bitstream (req_bitstream),
    .req_ready     (req_ready),
    .rca_busy      (rca_busy),
    .rca_lock      (rca_lock),
    .pr_start      (pr_start),
    .pr_rca        (pr_rca),
    .pr_bitstream  (pr_bitstream),
    .pr_done       (pr_done),
    .queue_count   (queue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns with ok=1 on the cycle pr_start is visible, or ok=0 after a bounded wait.
  task automatic wait_start(output bit ok);
    int n = 0;
    while (pr_start !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    ok = (pr_start === 1'b1);
  endtask

  task automatic push_one(input logic [1:0] rca, input logic [7:0] bs);
    req_valid = 1'b1; req_rca = rca; req_bitstream = bs;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    checks++; if (queue_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", queue_count); end
    checks++; if (rca_lock !== 4'b0000) begin errors++; $display("FAIL reset_lock: got %b want 0000", rca_lock); end
    checks++; if (pr_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", pr_start); end
    checks++; if ({pr_rca, pr_bitstream} !== 10'd0) begin errors++; $display("FAIL reset_pr: got %0h/%0h want 0/0", pr_rca, pr_bitstream); end
  endtask

  task automatic test_single();
    push_one(2'd2, 8'h15);
    checks++; if (queue_count !== 4'd1) begin errors++; $display("FAIL single_cnt_n: got %0d want 1", queue_count); end
    checks++; if (rca_lock !== 4'b0000) begin errors++; $display("FAIL single_lock_n: got %b want 0000", rca_lock); end
    tick();
    checks++; if (queue_count !== 4'd0) begin errors++; $display("FAIL single_cnt_pop: got %0d want 0", queue_count); end
    checks++; if (rca_lock !== 4'b0100) begin errors++; $display("FAIL single_lock_wait: got %b want 0100", rca_lock); end
    checks++; if (pr_start !== 1'b0) begin errors++; $display("FAIL single_early_start: got %b want 0", pr_start); end
    checks++; if (pr_rca !== 2'd2 || pr_bitstream !== 8'h15) begin errors++; $display("FAIL single_pr: got %0d/%0h want 2/15", pr_rca, pr_bitstream); end
    tick();
    checks++; if (pr_start !== 1'b1) begin errors++; $display("FAIL single_start_n3: got %b want 1", pr_start); end
    tick();
    checks++; if (pr_start !== 1'b0) begin errors++; $display("FAIL single_start_pulse: got %b want 0", pr_start); end
    checks++; if (rca_lock !== 4'b0100) begin errors++; $display("FAIL single_lock_prog: got %b want 0100", rca_lock); end
    pr_done = 1'b1;
    tick();
    pr_done = 1'b0;
    checks++; if (rca_lock !== 4'b0000) begin errors++; $display("FAIL single_lock_done: got %b want 0000", rca_lock); end
    checks++; if (pr_rca !== 2'd2 || pr_bitstream !== 8'h15) begin errors++; $display("FAIL single_hold: got %0d/%0h want 2/15", pr_rca, pr_bitstream); end
  endtask

  task automatic test_busy_wait();
    bit ok;
    rca_busy = 4'b0010;
    push_one(2'd1, 8'h33);
    tick();
    for (int i = 0; i < 10; i++) begin
      checks++; if (pr_start !== 1'b0 || rca_lock !== 4'b0010) begin errors++; $display("FAIL busy_hold[%0d]: got start=%b lock=%b want 0/0010", i, pr_start, rca_lock); end
      tick();
    end
    rca_busy = 4'b0000;
    tick();
    checks++; if (pr_start !== 1'b1) begin errors++; $display("FAIL busy_release_start: got %b want 1", pr_start); end
    checks++; if (pr_rca !== 2'd1) begin errors++; $display("FAIL busy_rca: got %0d want 1", pr_rca); end
    pr_done = 1'b1;
    tick();
    pr_done = 1'b0;
    ok = 1'b1;
  endtask

  task automatic test_done_idle();
    pr_done = 1'b1;
    tick();
    pr_done = 1'b0;
    checks++; if (queue_count !== 4'd0 || rca_lock !== 4'b0000 || pr_start !== 1'b0) begin errors++; $display("FAIL idle_done: got cnt=%0d lock=%b start=%b want 0/0000/0", queue_count, rca_lock, pr_start); end
    push_one(2'd3, 8'h5A);
    tick();
    checks++; if (pr_start !== 1'b0) begin errors++; $display("FAIL idle_done_n2: got %b want 0", pr_start); end
    tick();
    checks++; if (pr_start !== 1'b1 || pr_bitstream !== 8'h5A) begin errors++; $display("FAIL idle_done_n3: got %b/%0h want 1/5a", pr_start, pr_bitstream); end
    pr_done = 1'b1;
    tick();
    pr_done = 1'b0;
  endtask

  task automatic test_full();
    bit ok;
    push_one(2'd0, 8'hA0);
    wait_start(ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_first_start: got timeout want pr_start"); end
    for (int i = 0; i < 9; i++) begin
      req_valid = 1'b1; req_rca = 2'(i % 4); req_bitstream = 8'h40 + 8'(i);
      tick();
    end
    req_valid = 1'b0;
    checks++; if (queue_count !== 4'd8) begin errors++; $display("FAIL full_count: got %0d want 8", queue_count); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", req_ready); end
    for (int k = 0; k < 8; k++) begin
      pr_done = 1'b1;
      tick();
      pr_done = 1'b0;
      wait_start(ok);
      checks++;
      if (!ok || pr_bitstream !== 8'h40 + 8'(k) || pr_rca !== 2'(k % 4)) begin
        errors++;
        $display("FAIL full_order[%0d]: got start=%b %0d/%0h want 1 %0d/%0h", k, ok, pr_rca, pr_bitstream, k % 4, 8'h40 + 8'(k));
      end
    end
    pr_done = 1'b1;
    tick();
    pr_done = 1'b0;
    tick();
    checks++; if (queue_count !== 4'd0 || rca_lock !== 4'b0000) begin errors++; $display("FAIL full_drained: got cnt=%0d lock=%b want 0/0000", queue_count, rca_lock); end
  endtask

  task automatic test_dedup();
    int starts = 0;
    pr_done = 1'b1;
    push_one(2'd0, 8'h07);
    checks++; if (queue_count !== 4'd1) begin errors++; $display("FAIL dedup_first: got %0d want 1", queue_count); end
    push_one(2'd0, 8'h07);
`ifdef RCA_PR_DEDUP_EN
    checks++; if (queue_count !== 4'd0) begin errors++; $display("FAIL dedup_second: got %0d want 0", queue_count); end
`else
    checks++; if (queue_count !== 4'd1) begin errors++; $display("FAIL dedup_second: got %0d want 1", queue_count); end
`endif
    for (int i = 0; i < 30; i++) begin
      if (pr_start === 1'b1) starts++;
      tick();
    end
    pr_done = 1'b0;
`ifdef RCA_PR_DEDUP_EN
    checks++; if (starts != 1) begin errors++; $display("FAIL dedup_starts: got %0d want 1", starts); end
`else
    checks++; if (starts != 2) begin errors++; $display("FAIL dedup_starts: got %0d want 2", starts); end
`endif
    checks++; if (rca_lock !== 4'b0000 || queue_count !== 4'd0) begin errors++; $display("FAIL dedup_idle: got lock=%b cnt=%0d want 0000/0", rca_lock, queue_count); end
  endtask

  task automatic test_reset_mid_program();
    bit ok;
    push_one(2'd3, 8'h11);
    wait_start(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_mid_start: got timeout want pr_start"); end
    for (int k = 0; k < 3; k++) push_one(2'd1, 8'h21 + 8'(k));
    checks++; if (queue_count !== 4'd3 || rca_lock !== 4'b1000) begin errors++; $display("FAIL rst_mid_setup: got cnt=%0d lock=%b want 3/1000", queue_count, rca_lock); end
    rst = 1'b1;
    #1;
    checks++; if (rca_lock !== 4'b0000) begin errors++; $display("FAIL rst_mid_lock: got %b want 0000", rca_lock); end
    checks++; if (queue_count !== 4'd0 || req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_queue: got cnt=%0d ready=%b want 0/1", queue_count, req_ready); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (pr_start !== 1'b0 || rca_lock !== 4'b0000) begin errors++; $display("FAIL rst_mid_after[%0d]: got start=%b lock=%b want 0/0000", i, pr_start, rca_lock); end
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_rca = '0; req_bitstream = '0;
    rca_busy = '0; pr_done = 1'b0;
    tick();
    tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_single();
    test_busy_wait();
    test_done_idle();
    test_full();
    test_dedup();
    test_reset_mid_program();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
